// File: rtl/dead_time_gen_pkg.sv
// dead_time_gen_pkg: shared state encodings, default sizes and leg-order names for the gate-drive stage
package dead_time_gen_pkg;
   localparam int NLEGS_DEF = 6;
   localparam int DT_W_DEF  = 8;
   typedef enum logic [1:0] {IDLE, DEAD, ON_HI, ON_LO} state_t;
   // bit position of each leg within sw_in / gate_hi / gate_lo / dead_act
   typedef enum logic [2:0] {
      LEG_BR1_L0, LEG_BR1_L1, LEG_BR2_L0, LEG_BR2_L1, LEG_BR3_L0, LEG_BR3_L1
   } leg_t;
endpackage

// File: rtl/dead_time_gen_leg.sv
// dead_time_leg: one half-bridge leg, complementary gates with programmable dead time
//   clk, rst (async, active-low), en_q (registered enable), sw (raw switching bit),
//   dt (dead time, clamped to >=1), gate_hi/gate_lo (registered gates), dead_act (IDLE or DEAD)
module dead_time_leg import dead_time_gen_pkg::*; #(
   parameter int DT_W = DT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_q,
   input  logic            sw,
   input  logic [DT_W-1:0] dt,
   output logic            gate_hi,
   output logic            gate_lo,
   output logic            dead_act
);
   state_t state, state_nx;
   logic [DT_W-1:0] cnt, cnt_nx, dt_c;
   logic in_q, tgt, tgt_nx;
   assign dt_c = (dt == '0) ? DT_W'(1) : dt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         tgt      <= 1'b0;
         in_q     <= 1'b0;
         gate_hi  <= 1'b0;
         gate_lo  <= 1'b0;
         dead_act <= 1'b1;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         tgt      <= tgt_nx;
         in_q     <= sw;
         // gates decoded from the next state so they switch on the same edge as the FSM
         gate_hi  <= state_nx == ON_HI;
         gate_lo  <= state_nx == ON_LO;
         dead_act <= state_nx == IDLE || state_nx == DEAD;
      end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tgt_nx   = tgt;
      if (!en_q) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else
         case (state)
            IDLE: begin
               state_nx = DEAD;
               cnt_nx   = dt_c;
               tgt_nx   = in_q;
            end
            DEAD:
               // a changed command restarts the full dead time toward the new target
               if (in_q != tgt) begin
                  tgt_nx = in_q;
                  cnt_nx = dt_c;
               end else if (cnt == DT_W'(1))
                  state_nx = tgt ? ON_HI : ON_LO;
               else
                  cnt_nx = cnt - DT_W'(1);
            ON_HI:
               if (!in_q) begin
                  state_nx = DEAD;
                  tgt_nx   = 1'b0;
                  cnt_nx   = dt_c;
               end
            ON_LO:
               if (in_q) begin
                  state_nx = DEAD;
                  tgt_nx   = 1'b1;
                  cnt_nx   = dt_c;
               end
            default: state_nx = IDLE;
         endcase
   end
endmodule

// File: rtl/dead_time_gen.sv
// dead_time_gen: dead-time insertion for the six modulator legs with global gate enable
//   clk, rst (async, active-low), en (low forces all gates off), dt (dead time in cycles),
//   sw_in (1 = upper on), gate_hi/gate_lo (complementary gates), dead_act (leg in IDLE or DEAD)
module dead_time_gen import dead_time_gen_pkg::*; #(
   parameter int NLEGS = NLEGS_DEF,
   parameter int DT_W  = DT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DT_W-1:0]  dt,
   input  logic [NLEGS-1:0] sw_in,
   output logic [NLEGS-1:0] gate_hi,
   output logic [NLEGS-1:0] gate_lo,
   output logic [NLEGS-1:0] dead_act
);
   logic en_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) en_q <= 1'b0;
      else en_q <= en;
   for (genvar i = 0; i < NLEGS; i++) begin : g_leg
      dead_time_leg #(.DT_W(DT_W)) u_leg (
         .clk      (clk),
         .rst      (rst),
         .en_q     (en_q),
         .sw       (sw_in[i]),
         .dt       (dt),
         .gate_hi  (gate_hi[i]),
         .gate_lo  (gate_lo[i]),
         .dead_act (dead_act[i])
      );
   end
endmodule
